// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM-stage access unit: RV32I funct3 codes, FSM states and
// access-size helpers.
package mem_access_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Unlisted codes (011/110/111) fall through to a word access.
  function automatic acc_size_e f3_size(input logic [2:0] f3);
    acc_size_e sz;
    case (f3)
      F3_LB, F3_LBU: sz = SZ_BYTE;
      F3_LH, F3_LHU: sz = SZ_HALF;
      F3_LW:         sz = SZ_WORD;
      default:       sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    case (f3_size(f3))
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = (off[0] == 1'b0);
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_stage_lsu_lane_align.sv
// Byte-lane steering: store strobes and data replication, load lane select and extension.
module lsu_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [31:0] shifted;

  always_comb begin
    wstrb_o = 4'b1111;
    wdata_o = wdata_i;
    case (funct3_i)
      F3_SB: begin
        wstrb_o = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      F3_SH: begin
        wstrb_o = 4'b0011 << off_i;
        wdata_o = {2{wdata_i[15:0]}};
      end
      F3_SW:   wstrb_o = 4'b1111;
      default: wstrb_o = 4'b1111;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extending.
  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    case (f3_size(funct3_i))
      SZ_BYTE: load_o = funct3_i[2] ? {24'b0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_o = funct3_i[2] ? {16'b0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      default: load_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: issues req/ack transactions, extends load data and
// stalls the pipeline until the access completes.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_MemAcc,
  input  logic        rst_MemAcc,
  input  logic        valid_in_MemAcc,
  input  logic        MemRead_in_MemAcc,
  input  logic        MemWrite_in_MemAcc,
  input  logic [2:0]  funct3_in_MemAcc,
  input  logic [31:0] Addr_in_MemAcc,
  input  logic [31:0] Wdata_in_MemAcc,
  output logic        Dmem_req_out,
  output logic        Dmem_we_out,
  output logic [31:0] Dmem_addr_out,
  output logic [31:0] Dmem_wdata_out,
  output logic [3:0]  Dmem_wstrb_out,
  input  logic        Dmem_ack_in,
  input  logic [31:0] Dmem_rdata_in,
  output logic [31:0] Load_data_out_MemAcc,
  output logic        stall_out_MemAcc,
  output logic        misalign_out_MemAcc,
  output logic        buserr_out_MemAcc,
  output logic [1:0]  state_dbg_o
);

  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  // Handshake: Dmem_req_out rises with the address/data/strobes and all stay stable
  // until the first cycle Dmem_ack_in is seen high in BUSY; rdata is taken in that cycle.
  mem_state_e  state_q;
  logic [7:0]  cnt_q;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q, load_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        misalign_q, buserr_q;

  logic        memop, is_read, aligned_in, timeout_hit;
  logic [8:0]  cnt_nxt;
  logic [2:0]  lane_f3;
  logic [1:0]  lane_off;
  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata, lane_load;

  assign memop       = valid_in_MemAcc & (MemRead_in_MemAcc | MemWrite_in_MemAcc);
  assign is_read     = MemRead_in_MemAcc;
  assign aligned_in  = is_aligned(funct3_in_MemAcc, Addr_in_MemAcc[1:0]);
  assign cnt_nxt     = {1'b0, cnt_q} + 9'd1;
  assign timeout_hit = (cnt_nxt == TIMEOUT_W);

  // One lane unit serves both phases: stores are steered from the live inputs in IDLE,
  // loads are extended from the latched access in BUSY.
  assign lane_f3  = (state_q == ST_IDLE) ? funct3_in_MemAcc    : f3_q;
  assign lane_off = (state_q == ST_IDLE) ? Addr_in_MemAcc[1:0] : off_q;

  lsu_lane_align u_lane (
    .funct3_i (lane_f3),
    .off_i    (lane_off),
    .wdata_i  (Wdata_in_MemAcc),
    .rdata_i  (Dmem_rdata_in),
    .wstrb_o  (lane_wstrb),
    .wdata_o  (lane_wdata),
    .load_o   (lane_load)
  );

  always_ff @(posedge clk_MemAcc) begin
    if (rst_MemAcc) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      f3_q       <= 3'd0;
      off_q      <= 2'd0;
      load_q     <= 32'd0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (memop && aligned_in) begin
            state_q <= ST_BUSY;
            cnt_q   <= 8'd0;
            req_q   <= 1'b1;
            we_q    <= ~is_read;
            addr_q  <= {Addr_in_MemAcc[31:2], 2'b00};
            wdata_q <= is_read ? 32'd0 : lane_wdata;
            wstrb_q <= is_read ? 4'd0  : lane_wstrb;
            f3_q    <= funct3_in_MemAcc;
            off_q   <= Addr_in_MemAcc[1:0];
          end else if (memop) begin
            misalign_q <= 1'b1;
            load_q     <= 32'd0;
          end
        end
        ST_BUSY: begin
          // Ack is checked first so it wins over a timeout in the same cycle.
          if (Dmem_ack_in) begin
            load_q  <= we_q ? 32'd0 : lane_load;
            req_q   <= 1'b0;
            state_q <= ST_DONE;
          end else if (timeout_hit) begin
            load_q   <= 32'd0;
            req_q    <= 1'b0;
            buserr_q <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_nxt[7:0];
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall_out_MemAcc     = ((state_q == ST_IDLE) & memop & aligned_in) | (state_q == ST_BUSY);
  assign Dmem_req_out         = req_q;
  assign Dmem_we_out          = we_q;
  assign Dmem_addr_out        = addr_q;
  assign Dmem_wdata_out       = wdata_q;
  assign Dmem_wstrb_out       = wstrb_q;
  assign Load_data_out_MemAcc = load_q;
  assign misalign_out_MemAcc  = misalign_q;
  assign buserr_out_MemAcc    = buserr_q;
  assign state_dbg_o          = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a size/offset arithmetic reference model.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  localparam int TP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, mrd, mwr;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic        req, we;
  logic [31:0] daddr, dwdata;
  logic [3:0]  wstrb;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] load;
  logic        stall, misalign, buserr;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  mem_access_stage #(.TIMEOUT(TP)) dut (
    .clk_MemAcc           (clk),
    .rst_MemAcc           (rst),
    .valid_in_MemAcc      (valid),
    .MemRead_in_MemAcc    (mrd),
    .MemWrite_in_MemAcc   (mwr),
    .funct3_in_MemAcc     (f3),
    .Addr_in_MemAcc       (addr),
    .Wdata_in_MemAcc      (wdata),
    .Dmem_req_out         (req),
    .Dmem_we_out          (we),
    .Dmem_addr_out        (daddr),
    .Dmem_wdata_out       (dwdata),
    .Dmem_wstrb_out       (wstrb),
    .Dmem_ack_in          (ack),
    .Dmem_rdata_in        (rdata),
    .Load_data_out_MemAcc (load),
    .stall_out_MemAcc     (stall),
    .misalign_out_MemAcc  (misalign),
    .buserr_out_MemAcc    (buserr),
    .state_dbg_o          (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] fn);
    if (fn == 3'd0 || fn == 3'd4) return 1;
    if (fn == 3'd1 || fn == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic ref_aligned(input logic [2:0] fn, input logic [31:0] a);
    return (a % ref_size(fn)) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] fn, input logic [31:0] a,
                                           input logic [31:0] rd);
    int sz = ref_size(fn);
    logic [31:0] v = rd >> (8 * (a % 4));
    logic sgn = (fn < 3'd4);
    if (sz == 1) begin
      v = v % 256;
      if (sgn && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = v % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_wstrb(input logic [2:0] fn, input logic [31:0] a);
    int sz = ref_size(fn);
    if (sz == 4) return 4'hF;
    return 4'(((1 << sz) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] fn, input logic [31:0] w);
    int sz = ref_size(fn);
    if (sz == 1) return (w % 256) * 32'h01010101;
    if (sz == 2) return (w % 65536) * 32'h00010001;
    return w;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1 with the DUT idle; ack_dly = BUSY cycle index of ack (>=TP: none).
  task automatic run_op(input logic rd_i, input logic wr_i, input logic vld_i,
                        input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd,
                        input int ack_dly, input logic [31:0] rdat);
    logic memop, ok, is_ld, timed_out;
    int stalls, k, exp_stalls;
    logic [31:0] exp_load;
    memop = vld_i && (rd_i || wr_i);
    ok    = ref_aligned(fn, a);
    is_ld = rd_i;
    timed_out = (ack_dly >= TP);
    valid = vld_i; mrd = rd_i; mwr = wr_i; f3 = fn; addr = a; wdata = wd; ack = 1'b0;
    #1;
    check_eq("idle_stall", 32'(stall), 32'(memop && ok));
    if (!memop) begin
      @(posedge clk); #1;
      check_eq("nomem_req", 32'(req), 32'd0);
      check_eq("nomem_state", 32'(state_dbg), 32'(ST_IDLE));
      valid = 1'b0;
      return;
    end
    if (!ok) begin
      @(posedge clk); #1;
      check_eq("mis_pulse", 32'(misalign), 32'd1);
      check_eq("mis_req", 32'(req), 32'd0);
      check_eq("mis_load", load, 32'd0);
      check_eq("mis_stall", 32'(stall), 32'd0);
      valid = 1'b0;
      @(posedge clk); #1;
      check_eq("mis_pulse_end", 32'(misalign), 32'd0);
      return;
    end
    stalls = 1;
    @(posedge clk); #1;
    check_eq("busy_req", 32'(req), 32'd1);
    check_eq("busy_we", 32'(we), 32'(!is_ld));
    check_eq("busy_addr", daddr, {a[31:2], 2'b00});
    check_eq("busy_wstrb", 32'(wstrb), is_ld ? 32'd0 : 32'(ref_wstrb(fn, a)));
    if (!is_ld) check_eq("busy_wdata", dwdata, ref_wdata(fn, wd));
    exp_q.push_back(timed_out ? 32'd0 : (is_ld ? ref_load(fn, a, rdat) : 32'd0));
    k = 0;
    while (stall === 1'b1 && k < 64) begin
      if (req !== 1'b1) check_eq("busy_req_held", 32'(req), 32'd1);
      stalls++;
      ack   = (k == ack_dly);
      rdata = (k == ack_dly) ? rdat : $urandom;
      @(posedge clk); #1;
      ack = 1'b0;
      k++;
    end
    exp_stalls = 1 + (timed_out ? TP : ack_dly + 1);
    check_eq("stall_cycles", 32'(stalls), 32'(exp_stalls));
    exp_load = exp_q.pop_front();
    check_eq("done_state", 32'(state_dbg), 32'(ST_DONE));
    check_eq("done_req", 32'(req), 32'd0);
    check_eq("done_load", load, exp_load);
    check_eq("done_buserr", 32'(buserr), 32'(timed_out));
    // A stray ack in DONE must not start anything or disturb the result.
    ack = 1'b1; rdata = $urandom;
    @(posedge clk); #1;
    ack = 1'b0; valid = 1'b0;
    check_eq("post_state", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("post_req", 32'(req), 32'd0);
    check_eq("post_buserr", 32'(buserr), 32'd0);
    check_eq("post_load_held", load, exp_load);
  endtask

  task automatic reset_in_busy();
    valid = 1'b1; mrd = 1'b1; mwr = 1'b0; f3 = F3_LW; addr = 32'h200; ack = 1'b0;
    @(posedge clk); #1;
    check_eq("rb_req", 32'(req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rb_req_drop", 32'(req), 32'd0);
    check_eq("rb_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0; valid = 1'b0; ack = 1'b1; rdata = 32'h12345678;
    @(posedge clk); #1;
    ack = 1'b0;
    check_eq("rb_late_ack_req", 32'(req), 32'd0);
    check_eq("rb_late_ack_state", 32'(state_dbg), 32'(ST_IDLE));
    check_eq("rb_late_ack_load", load, 32'd0);
    check_eq("rb_stall", 32'(stall), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0] fn;
    logic [31:0] a;
    int kind;
    rst = 1'b1; valid = 1'b0; mrd = 1'b0; mwr = 1'b0; f3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; ack = 1'b0; rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req", 32'(req), 32'd0);
    check_eq("rst_we", 32'(we), 32'd0);
    check_eq("rst_addr", daddr, 32'd0);
    check_eq("rst_wdata", dwdata, 32'd0);
    check_eq("rst_wstrb", 32'(wstrb), 32'd0);
    check_eq("rst_load", load, 32'd0);
    check_eq("rst_misalign", 32'(misalign), 32'd0);
    check_eq("rst_buserr", 32'(buserr), 32'd0);
    check_eq("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1, 0, 1, F3_LW,  32'h100, 32'd0, 0, 32'hDEADBEEF);
    run_op(1, 0, 1, F3_LB,  32'h103, 32'd0, 0, 32'h80112233);
    run_op(1, 0, 1, F3_LBU, 32'h103, 32'd0, 0, 32'h80112233);
    run_op(0, 1, 1, F3_SH,  32'h22,  32'h0000ABCD, 1, 32'd0);
    run_op(1, 0, 1, F3_LW,  32'h101, 32'd0, 0, 32'd0);
    run_op(1, 0, 1, F3_LW,  32'h40,  32'd0, 99, 32'h55AA55AA);
    run_op(1, 0, 1, F3_LH,  32'h42,  32'd0, TP - 1, 32'h8001_7FFF);
    run_op(1, 1, 1, F3_LHU, 32'h46,  32'hFFFF_FFFF, 2, 32'hBEEF_1234);
    run_op(1, 0, 0, F3_LW,  32'h80,  32'd0, 0, 32'd0);
    run_op(0, 1, 1, F3_SB,  32'h13,  32'h0000_00C3, 0, 32'd0);
    reset_in_busy();

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      a    = $urandom;
      if (kind >= 6 && kind <= 8) fn = 3'($urandom_range(0, 3));
      else                        fn = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) a = a - (a % ref_size(fn));
      case (kind)
        0:       run_op($urandom_range(0, 1) == 1, 0, 0, fn, a, $urandom, 0, $urandom);
        9:       run_op(1, 1, 1, fn, a, $urandom, $urandom_range(0, TP + 1), $urandom);
        6, 7, 8: run_op(0, 1, 1, fn, a, $urandom, $urandom_range(0, TP + 1), $urandom);
        default: run_op(1, 0, 1, fn, a, $urandom, $urandom_range(0, TP + 1), $urandom);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
